wb_arbiter: RTL

Writeback arbiter between the EX and MEM result sources and the single register-file write port. Both stages may produce a result in the same cycle. The arbiter accepts both, orders them oldest-first (MEM before EX), buffers the overflow in a small in-order queue, and drains exactly one write per cycle to the register file. It sits between the EX/MEM stage outputs and the regfile write port, and its ready outputs feed the pipeline stall logic.

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EX and MEM results oldest-first into one registered
// regfile write per cycle, buffering overflow in a small circular queue.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_mem_valid,
  output logic                       o_mem_ready,
  input  logic [4:0]                 i_mem_rd_addr,
  input  logic [31:0]                i_mem_rd_data,
  input  logic                       i_ex_valid,
  output logic                       o_ex_ready,
  input  logic [4:0]                 i_ex_rd_addr,
  input  logic [31:0]                i_ex_rd_data,
  output logic                       o_rd_we,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MEM_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] EX_MAX  = CW'(DEPTH - 2);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t           q_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;

  wr_t  mem_in, ex_in, out_nxt, push0, push1;
  logic acc_mem, acc_ex, pop, out_en, push0_en, push1_en;

  // Readies come from registered count only, so they never combine with valids.
  assign o_mem_ready = (count <= MEM_MAX);
  assign o_ex_ready  = (count <= EX_MAX);
  assign o_count     = count;

  assign mem_in = '{addr: i_mem_rd_addr, data: i_mem_rd_data};
  assign ex_in  = '{addr: i_ex_rd_addr,  data: i_ex_rd_data};

  // x0 writes complete their handshake but never become candidates.
  assign acc_mem = i_mem_valid && o_mem_ready && (i_mem_rd_addr != 5'd0);
  assign acc_ex  = i_ex_valid  && o_ex_ready  && (i_ex_rd_addr  != 5'd0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    out_en   = 1'b0;
    out_nxt  = '0;
    push0_en = 1'b0;
    push0    = '0;
    push1_en = 1'b0;
    push1    = '0;
    pop      = (count != '0);

    // Candidate order: queue head, MEM, EX. First goes out, the rest queue up.
    if (pop) begin
      out_en  = 1'b1;
      out_nxt = q_mem[rd_ptr];
      if (acc_mem) begin
        push0_en = 1'b1;
        push0    = mem_in;
        push1_en = acc_ex;
        push1    = ex_in;
      end else begin
        push0_en = acc_ex;
        push0    = ex_in;
      end
    end else if (acc_mem) begin
      out_en   = 1'b1;
      out_nxt  = mem_in;
      push0_en = acc_ex;
      push0    = ex_in;
    end else if (acc_ex) begin
      out_en  = 1'b1;
      out_nxt = ex_in;
    end

    count_nxt  = count + CW'(push0_en) + CW'(push1_en) - CW'(pop);
    wr_ptr_nxt = wr_ptr + PW'(push0_en) + PW'(push1_en);
    rd_ptr_nxt = rd_ptr + PW'(pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      o_rd_we   <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
      o_empty   <= 1'b1;
    end else begin
      count   <= count_nxt;
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      o_rd_we <= out_en;
      o_empty <= (count_nxt == '0) && !out_en;
      if (out_en) begin
        o_rd_addr <= out_nxt.addr;
        o_rd_data <= out_nxt.data;
      end
    end
  end

  // NOTE: queue storage has no reset; entries are only read once the reset
  // pointers and count mark them valid, so clearing them would buy nothing.
  always_ff @(posedge i_clk) begin
    if (push0_en) q_mem[wr_ptr] <= push0;
    if (push1_en) q_mem[wr_ptr + PW'(1)] <= push1;
  end

endmodule
